store_unit: RTL and testbench

Write-side counterpart to the CPU's word-array memories: accepts RISC-V store requests (SB/SH/SW) with arbitrary byte addresses and turns each into one or two word-indexed, byte-strobed write beats. Little-endian. Misaligned halfword/word stores that cross a 32-bit word boundary are split into two consecutive beats. It sits between the execute/memory stage and any word-organised RAM with per-byte write enables.

---
 rtl/store_unit.sv | 155 +++++++++++++++
 tb/tb_store_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Purpose: turns SB/SH/SW stores at any byte address into one or two byte-strobed word write beats.
// Latency: beat 0 and done one cycle after acceptance; a word-crossing store adds a second beat, and done moves to that beat.
// Backpressure: req_ready is high only in IDLE; a request presented while busy is ignored.
module store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [2:0]            store_type,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

    state_t state, state_n;

    // Second beat is computed at acceptance and parked until the BEAT0 cycle.
    logic [ADDR_WIDTH-2:0] b1_idx;
    logic [31:0]           b1_data;
    logic [3:0]            b1_strb;
    logic                  b1_ok;
    logic                  b1_pend;
    logic                  b0_err;

    logic                  accept;
    logic                  type_ok;
    logic [3:0]            base;
    logic [31:0]           masked;
    logic [7:0]            strb8;
    logic [63:0]           data64;
    logic [ADDR_WIDTH-3:0] word;
    logic [ADDR_WIDTH-2:0] word_p1;
    logic                  ok0;
    logic                  ok1;
    logic                  two;

    logic                  we_n;
    logic [ADDR_WIDTH-3:0] addr_n;
    logic [31:0]           wdata_n;
    logic [3:0]            wstrb_n;
    logic                  done_n;
    logic                  err_n;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        type_ok = 1'b1;
        base    = 4'b0000;
        masked  = 32'h0;
        case (store_type)
            3'b000:  begin base = 4'b0001; masked = {24'h0, req_data[7:0]};  end
            3'b001:  begin base = 4'b0011; masked = {16'h0, req_data[15:0]}; end
            3'b010:  begin base = 4'b1111; masked = req_data[31:0];          end
            default: type_ok = 1'b0;
        endcase
        word    = req_addr[ADDR_WIDTH-1:2];
        strb8   = {4'b0000, base} << req_addr[1:0];
        data64  = {32'h0, masked} << {req_addr[1:0], 3'b000};
        // One bit wider than the index so stepping past the top word lands out of range instead of at 0.
        word_p1 = {1'b0, word} + (ADDR_WIDTH-1)'(1);
        ok0     = {2'b00, word} < MEM_LIMIT;
        ok1     = {1'b0, word_p1} < MEM_LIMIT;
        two     = (strb8[7:4] != 4'b0000);
    end

    always_comb begin
        state_n = state;
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = 32'h0;
        wstrb_n = 4'b0000;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (type_ok) begin
                        state_n = BEAT0;
                        we_n    = ok0;
                        addr_n  = word;
                        wdata_n = data64[31:0];
                        wstrb_n = ok0 ? strb8[3:0] : 4'b0000;
                        done_n  = !two;
                        err_n   = !two && !ok0;
                    end else begin
                        state_n = ERR;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (b1_pend) begin
                    state_n = BEAT1;
                    we_n    = b1_ok;
                    addr_n  = b1_idx[ADDR_WIDTH-3:0];
                    wdata_n = b1_data;
                    wstrb_n = b1_ok ? b1_strb : 4'b0000;
                    done_n  = 1'b1;
                    err_n   = b0_err || !b1_ok;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b0;
            err       <= 1'b0;
            b1_idx    <= '0;
            b1_data   <= 32'h0;
            b1_strb   <= 4'b0000;
            b1_ok     <= 1'b0;
            b1_pend   <= 1'b0;
            b0_err    <= 1'b0;
        end else begin
            state     <= state_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_wstrb <= wstrb_n;
            done      <= done_n;
            err       <= err_n;
            if (accept) begin
                b1_idx  <= word_p1;
                b1_data <= data64[63:32];
                b1_strb <= strb8[7:4];
                b1_ok   <= ok1;
                b1_pend <= type_ok && two;
                b0_err  <= !ok0;
            end
        end
    end
endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  store_type;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit        inr;
        bit [29:0] addr;
        bit [31:0] wdata;
        bit [3:0]  wstrb;
    } beat_t;

    beat_t exp_b[2];
    int    exp_nb;
    bit    exp_err;

    store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .store_type(store_type),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte model: each stored byte goes to word (addr+i)/4, lane (addr+i)%4.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        int size;
        longint w0, ba, w;
        int k, lane;
        size = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : (t == 3'd2) ? 4 : 0;
        exp_err = (size == 0);
        for (int j = 0; j < 2; j++) begin
            exp_b[j].inr = 1'b0; exp_b[j].addr = '0; exp_b[j].wdata = '0; exp_b[j].wstrb = '0;
        end
        w0 = longint'(a) >> 2;
        for (int i = 0; i < size; i++) begin
            ba   = longint'(a) + i;
            w    = ba >> 2;
            k    = int'(w - w0);
            lane = int'(ba & 3);
            exp_b[k].wdata[lane*8 +: 8] = d[i*8 +: 8];
            exp_b[k].wstrb[lane]        = 1'b1;
        end
        exp_nb = (size == 0) ? 0 : (exp_b[1].wstrb != 0) ? 2 : 1;
        for (int j = 0; j < exp_nb; j++) begin
            exp_b[j].addr = 30'(w0 + j);
            exp_b[j].inr  = (w0 + j) < 512;
            if (!exp_b[j].inr) begin
                exp_err = 1'b1;
                exp_b[j].wstrb = 4'b0000;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_we"},    64'(mem_we),    64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_err"},   64'(err),       64'd0);
        chk({tag, "_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'd0);
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        model(a, d, t);
        @(negedge clk);
        chk("pre_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = a; req_data = d; store_type = t;
        @(posedge clk); #1;
        // Junk presented while busy must be ignored.
        req_valid  = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_data   = $urandom;
        store_type = 3'($urandom_range(0, 7));
        if (exp_nb == 0) begin
            chk("inv_we",    64'(mem_we),    64'd0);
            chk("inv_wstrb", 64'(mem_wstrb), 64'd0);
            chk("inv_done",  64'(done),      64'd1);
            chk("inv_err",   64'(err),       64'd1);
            chk("inv_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k < exp_nb; k++) begin
                chk("beat_we",    64'(mem_we),    64'(exp_b[k].inr));
                chk("beat_wstrb", 64'(mem_wstrb), 64'(exp_b[k].wstrb));
                if (exp_b[k].inr) begin
                    chk("beat_addr",  64'(mem_addr),  64'(exp_b[k].addr));
                    chk("beat_wdata", 64'(mem_wdata), 64'(exp_b[k].wdata));
                end
                chk("beat_done",  64'(done),      64'(k == exp_nb - 1));
                chk("beat_err",   64'(err),       64'((k == exp_nb - 1) && exp_err));
                chk("beat_ready", 64'(req_ready), 64'd0);
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        check_idle("after");
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; store_type = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        run_req(32'h103, 32'h123456AB, 3'b000);
        run_req(32'h00A, 32'h11223344, 3'b010);
        run_req(32'h007, 32'hFFFFBEEF, 3'b001);
        run_req(32'h7FE, 32'hCAFEF00D, 3'b010);
        run_req(32'h010, 32'h0,        3'b011);
        run_req(32'hFFFFFFFF, 32'hA5A5A5A5, 3'b001);
        run_req(32'h7FC, 32'hDEADBEEF, 3'b010);

        // Reset during BEAT0 of a two-beat store drops beat 1 and done.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0A; req_data = 32'h11223344; store_type = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstb_beat0_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstb_we",    64'(mem_we),    64'd0);
        chk("rstb_done",  64'(done),      64'd0);
        chk("rstb_ready", 64'(req_ready), 64'd1);
        // A request presented with rst high is not accepted.
        req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check_idle("rst_noacc");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [2:0]  t;
            int r;
            r = int'($urandom_range(0, 2));
            a = (r == 0) ? 32'($urandom_range(0, 32'h900)) :
                (r == 1) ? 32'h7F8 + 32'($urandom_range(0, 15)) :
                           32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            r = int'($urandom_range(0, 7));
            t = (r < 7) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            run_req(a, $urandom, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
